user_module_vote_capture: RTL and testbench



---
 rtl/user_module_vote_capture.sv | 137 +++++++++++++
 tb/tb_user_module_vote_capture.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/user_module_vote_capture.sv
`default_nettype none
// ============================================================================
// Module   : user_module_vote_capture
// Brief    : Six-voter ballot capture: sync/debounce, timed window, hold.
// Revision : 1.0
// ============================================================================
module user_module_vote_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW_CYCLES   = 64,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [3:0] C_DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] C_WIN_LAST  = 8'(WINDOW_CYCLES - 1);
  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  logic       clk;
  logic       rst;
  logic [5:0] w_btn;
  logic [5:0] w_press;

  assign clk   = io_in[0];
  assign rst   = io_in[1];
  assign w_btn = io_in[7:2];

  for (genvar i = 0; i < 6; i++) begin : g_chan
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       deb_q, deb_d;
    logic       deb_prev_q, deb_prev_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
      s1_d       = w_btn[i];
      s2_d       = s1_q;
      deb_prev_d = deb_q;
      deb_d      = deb_q;
      cnt_d      = 4'd0;
      // The counter only runs while the synchronised level disagrees with deb.
      if (s2_q != deb_q) begin
        if (cnt_q == C_DEB_LAST) begin
          deb_d = ~deb_q;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q       <= 1'b0;
        s2_q       <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= 4'd0;
      end else begin
        s1_q       <= s1_d;
        s2_q       <= s2_d;
        deb_q      <= deb_d;
        deb_prev_q <= deb_prev_d;
        cnt_q      <= cnt_d;
      end
    end

    assign w_press[i] = deb_q & ~deb_prev_q;
  end

  state_t     state_q, state_d;
  logic [5:0] vote_q, vote_d;
  logic [7:0] win_q, win_d;
  logic [7:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    vote_d  = vote_q;
    win_d   = win_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        vote_d = 6'd0;
        if (|w_press) begin
          vote_d  = w_press;
          win_d   = 8'd0;
          state_d = ST_OPEN;
        end
      end
      ST_OPEN: begin
        // Presses on the closing edge still land in the ballot.
        vote_d = vote_q | w_press;
        win_d  = win_q + 8'd1;
        if ((win_q == C_WIN_LAST) || (vote_q == 6'h3F)) begin
          hold_d  = 8'd0;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (hold_q == C_HOLD_LAST) begin
          vote_d  = 6'd0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        vote_d  = 6'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vote_q  <= 6'd0;
      win_q   <= 8'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      vote_q  <= vote_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
    end
  end

  assign io_out = {(state_q == ST_OPEN), (state_q == ST_PRESENT), vote_q};

endmodule
`default_nettype wire

// File: tb/tb_user_module_vote_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_user_module_vote_capture
// Brief    : Self-checking bench for the vote capture front end (defaults).
// Revision : 1.0
// ============================================================================
module tb_user_module_vote_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] btn = 6'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  logic [7:0] exp_q[$];
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  assign io_in = {btn, rst, clk};

  user_module_vote_capture #(
    .DEBOUNCE_CYCLES(4),
    .WINDOW_CYCLES  (64),
    .HOLD_CYCLES    (16)
  ) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 6'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    rst = 1'b1;
    btn = 6'b101010;
    for (int t = 0; t < 12; t++) begin
      if (t < 2) btn = ~btn;
      if (t == 2) begin
        rst = 1'b0;
        btn = 6'd0;
      end
      exp_q.push_back(8'h00);
      tick();
      got = io_out;
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL reset edge %0d: io_out=%02h expected %02h", t + 1, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_single_vote();
    logic [7:0] got, exp;
    do_reset();
    for (int t = 0; t < 90; t++) begin
      int e;
      e = t + 1;
      if (t == 0)  btn[0] = 1'b1;
      if (t == 10) btn[0] = 1'b0;
      if (e < 7)       exp_q.push_back(8'h00);
      else if (e < 71) exp_q.push_back(8'h81);
      else if (e < 87) exp_q.push_back(8'h41);
      else             exp_q.push_back(8'h00);
      tick();
      got = io_out;
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL single_vote edge %0d: io_out=%02h expected %02h", e, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    logic [7:0] got, exp;
    do_reset();
    for (int t = 0; t < 20; t++) begin
      if (t == 0) btn[2] = 1'b1;
      if (t == 3) btn[2] = 1'b0;
      exp_q.push_back(8'h00);
      tick();
      got = io_out;
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL glitch edge %0d: io_out=%02h expected %02h", t + 1, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_early_close();
    logic [7:0] got, exp;
    do_reset();
    for (int t = 0; t < 55; t++) begin
      int e;
      logic [7:0] x;
      e = t + 1;
      if ((t % 5 == 0) && (t <= 25)) btn[t / 5] = 1'b1;
      // Voter i is pressed at t=5i and lands at edge 5i+7.
      x = 8'h00;
      if (e >= 7 && e < 33) begin
        x = 8'h80;
        for (int i = 0; i < 6; i++) if (e >= 5 * i + 7) x[i] = 1'b1;
      end else if (e >= 33 && e < 49) begin
        x = 8'h7F;
      end
      exp_q.push_back(x);
      tick();
      got = io_out;
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL early_close edge %0d: io_out=%02h expected %02h", e, got, exp);
      else pass_cnt++;
    end
    btn = 6'd0;
  endtask

  task automatic test_lockout();
    logic [7:0] got, exp;
    do_reset();
    for (int t = 0; t < 120; t++) begin
      int e;
      e = t + 1;
      if (t == 0)   btn[0] = 1'b1;
      if (t == 10)  btn[0] = 1'b0;
      if (t == 75)  btn[1] = 1'b1;
      if (t == 100) btn[1] = 1'b0;
      if (t == 110) btn[1] = 1'b1;
      if (e < 7)        exp_q.push_back(8'h00);
      else if (e < 71)  exp_q.push_back(8'h81);
      else if (e < 87)  exp_q.push_back(8'h41);
      else if (e < 117) exp_q.push_back(8'h00);
      else              exp_q.push_back(8'h82);
      tick();
      got = io_out;
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL lockout edge %0d: io_out=%02h expected %02h", e, got, exp);
      else pass_cnt++;
    end
    btn = 6'd0;
  endtask

  task automatic test_reset_mid_open();
    logic [7:0] got, exp;
    do_reset();
    for (int t = 0; t < 90; t++) begin
      int e;
      e = t + 1;
      if (t == 0) btn[1:0] = 2'b11;
      if (t == 10) begin
        rst    = 1'b1;
        btn[1] = 1'b0;
      end
      if (t == 11) rst = 1'b0;
      // btn[0] stays held through reset release and must re-debounce.
      if (e < 7)       exp_q.push_back(8'h00);
      else if (e < 11) exp_q.push_back(8'h83);
      else if (e < 18) exp_q.push_back(8'h00);
      else if (e < 82) exp_q.push_back(8'h81);
      else             exp_q.push_back(8'h41);
      tick();
      got = io_out;
      exp = exp_q.pop_front();
      chk_cnt++;
      if (got !== exp) $display("FAIL reset_mid_open edge %0d: io_out=%02h expected %02h", e, got, exp);
      else pass_cnt++;
    end
    btn = 6'd0;
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_glitch();
    test_early_close();
    test_lockout();
    test_reset_mid_open();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
